// File: rtl/fetch_unit.sv
// Instruction fetch unit.
// Issues one word-aligned fetch at a time to instruction memory, buffers the
// returned word in a single output register for the decoder, and handles
// branch/jump redirects. Responses for a fetch that was overtaken by a
// redirect are drained and dropped in the FLUSH state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction memory request channel
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    // instruction memory response channel
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    // decoder-facing channel
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    // redirect from execute
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign
);

    // Reset value of the instruction buffer: addi x0, x0, 0.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // REQ   : may issue a fetch when the output buffer is empty.
    // WAIT  : one fetch outstanding, its response will be captured.
    // FLUSH : one fetch outstanding, its response will be discarded.
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_q;         // next address to fetch
    logic [31:0] req_addr_q;   // address of the fetch currently outstanding
    logic        out_valid_q;  // output buffer holds an instruction
    logic [31:0] out_instr_q;
    logic [31:0] out_pc_q;
    logic        misalign_q;

    logic        req_fire;
    logic        xfer_fire;
    logic        redirect_unaligned;
    logic [31:0] redirect_aligned;

    // The request is qualified only by registered state and redirect_valid,
    // never by if_ready, so a transfer and a new fetch cannot share a cycle.
    assign imem_req_valid     = (state == REQ) & ~out_valid_q & ~redirect_valid;
    assign imem_addr          = pc_q;
    assign req_fire           = imem_req_valid & imem_req_ready;

    // A redirect hides the buffered instruction in the same cycle so it is
    // dropped rather than handed to the decoder.
    assign if_valid           = out_valid_q & ~redirect_valid;
    assign if_instr           = out_instr_q;
    assign if_pc              = out_pc_q;
    assign xfer_fire          = if_valid & if_ready;

    assign redirect_unaligned = (redirect_pc[1:0] != 2'b00);
    assign redirect_aligned   = {redirect_pc[31:2], 2'b00};
    assign fetch_misalign     = misalign_q;

    // Fetch FSM with all address, buffer and flag registers; redirect wins over every other event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= REQ;
            pc_q        <= {RESET_PC[31:2], 2'b00};
            req_addr_q  <= 32'h0000_0000;
            out_valid_q <= 1'b0;
            out_instr_q <= NOP_INSTR;
            out_pc_q    <= 32'h0000_0000;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= redirect_valid & redirect_unaligned;

            if (redirect_valid) begin
                pc_q        <= redirect_aligned;
                out_valid_q <= 1'b0;
                case (state)
                    REQ: begin
                        state <= REQ;
                    end
                    WAIT: begin
                        // A response landing with the redirect is the stale
                        // one; drop it here instead of draining it later.
                        state <= imem_rsp_valid ? REQ : FLUSH;
                    end
                    FLUSH: begin
                        // Keep draining unless the stale response is arriving
                        // right now, in which case nothing is left in flight.
                        state <= imem_rsp_valid ? REQ : FLUSH;
                    end
                    default: begin
                        state <= REQ;
                    end
                endcase
            end else begin
                if (xfer_fire) begin
                    out_valid_q <= 1'b0;
                end
                case (state)
                    REQ: begin
                        // Responses seen here belong to no request and are ignored.
                        if (req_fire) begin
                            req_addr_q <= pc_q;
                            pc_q       <= pc_q + 32'd4;
                            state      <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_rsp_valid) begin
                            out_instr_q <= imem_rdata;
                            out_pc_q    <= req_addr_q;
                            out_valid_q <= 1'b1;
                            state       <= REQ;
                        end
                    end
                    FLUSH: begin
                        if (imem_rsp_valid) begin
                            state <= REQ;
                        end
                    end
                    default: begin
                        state <= REQ;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected
// (pc, instr) pairs, a monitor pops them on every decoder transfer, and an
// instruction-memory model answers fetches with address-tagged words.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_misalign;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   xq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // memory model controls
    int          lat      = 1;
    logic        ovr_en   = 1'b0;
    logic [31:0] ovr_addr = 32'h0;
    logic [31:0] ovr_data = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        sb.push_back(e);
    endtask

    task automatic wait_sb(input int budget, input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(nm, sb.size(), 0);
    endtask

    // Instruction memory: one outstanding fetch, answered lat cycles after acceptance.
    initial begin
        logic        hs;
        logic        pend;
        int          cnt;
        logic [31:0] haddr;
        logic [31:0] paddr;
        imem_rsp_valid = 1'b0;
        imem_rdata     = 32'h0;
        pend  = 1'b0;
        cnt   = 0;
        paddr = 32'h0;
        forever begin
            @(negedge clk);
            hs    = rst_n && imem_req_valid && imem_req_ready;
            haddr = imem_addr;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (hs) begin
                    pend  = 1'b1;
                    cnt   = lat;
                    paddr = haddr;
                end
                if (pend) begin
                    if (cnt <= 1) begin
                        imem_rsp_valid = 1'b1;
                        imem_rdata     = (ovr_en && paddr == ovr_addr) ? ovr_data : mem_word(paddr);
                        pend           = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Monitor: every decoder transfer must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && if_valid) begin
                if (if_instr == 32'hDEADBEEF) begin
                    n_checks++;
                    $display("FAIL stale_instr: if_instr %h presented at pc %h", if_instr, if_pc);
                end
                if (if_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_xfer: pc %h instr %h with empty scoreboard", if_pc, if_instr);
                    end else begin
                        e = sb.pop_front();
                        chk("xfer_pc", if_pc, e.pc);
                        chk("xfer_instr", if_instr, e.instr);
                        xq.push_back(cyc);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int n;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b1;
        imem_req_ready = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_req_valid", imem_req_valid, 1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0000_0013);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_misalign", fetch_misalign, 0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0123;
        @(negedge clk);
        chk("rst_req_valid_redir", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rst_misalign_held", fetch_misalign, 0);
        chk("rst_addr_held", imem_addr, 32'h0);

        // sequential fetch, 1-cycle memory, decoder always ready
        push(32'h0000_0000, 32'hC0DE_0000);
        push(32'h0000_0004, 32'hC0DE_0004);
        push(32'h0000_0008, 32'hC0DE_0008);
        tick();
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        wait_sb(40, "seq_three_done");
        if_ready = 1'b0;
        if (xq.size() >= 3) begin
            chk("thru_gap_0", xq[1] - xq[0], 3);
            chk("thru_gap_1", xq[2] - xq[1], 3);
        end else begin
            chk("thru_count", xq.size(), 3);
        end

        // decoder back-pressure for 5 cycles
        push(32'h0000_000C, 32'hC0DE_000C);
        n = 0;
        @(negedge clk);
        while (!if_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_buffered", if_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", if_valid, 1);
            chk("stall_pc", if_pc, 32'h0000_000C);
            chk("stall_instr", if_instr, 32'hC0DE_000C);
            chk("stall_no_req", imem_req_valid, 0);
            tick();
            @(negedge clk);
        end
        tick();
        if_ready = 1'b1;
        @(negedge clk);
        chk("xfer_cycle_no_req", imem_req_valid, 0);
        tick();
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk("post_xfer_req", imem_req_valid, 1);
        chk("post_xfer_addr", imem_addr, 32'h0000_0010);
        chk("post_xfer_if_valid", if_valid, 0);

        // redirect in WAIT, stale response 2 cycles later
        lat      = 3;
        ovr_en   = 1'b1;
        ovr_addr = 32'h0000_0010;
        ovr_data = 32'hDEADBEEF;
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        chk("wait_redir_no_req", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("flush_no_req_0", imem_req_valid, 0);
        chk("flush_misalign", fetch_misalign, 0);
        tick();
        @(negedge clk);
        chk("flush_no_req_1", imem_req_valid, 0);
        tick();
        ovr_en = 1'b0;
        @(negedge clk);
        chk("after_flush_req", imem_req_valid, 1);
        chk("after_flush_addr", imem_addr, 32'h0000_0100);
        chk("after_flush_if_valid", if_valid, 0);

        // redirect in the same cycle as the response
        lat = 1;
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        chk("same_cycle_rsp_seen", imem_rsp_valid, 1);
        chk("same_cycle_if_valid", if_valid, 0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("drop_req", imem_req_valid, 1);
        chk("drop_addr", imem_addr, 32'h0000_0200);
        chk("drop_if_valid", if_valid, 0);

        // misaligned redirect
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        @(negedge clk);
        chk("misalign_before", fetch_misalign, 0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("misalign_pulse", fetch_misalign, 1);
        chk("misalign_addr", imem_addr, 32'h0000_0200);
        chk("misalign_req", imem_req_valid, 1);
        tick();
        @(negedge clk);
        chk("misalign_cleared", fetch_misalign, 0);

        // wrap-around at the top of the address space
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        push(32'hFFFF_FFFC, 32'hC0DE_FFFC);
        push(32'h0000_0000, 32'hC0DE_0000);
        imem_req_ready = 1'b1;
        wait_sb(40, "wrap_done");
        if_ready       = 1'b0;
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk("wrap_next_addr", imem_addr, 32'h0000_0004);

        // reset while a fetch is outstanding
        lat = 3;
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst_n          = 1'b0;
        @(negedge clk);
        chk("midrst_if_valid", if_valid, 0);
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_if_instr", if_instr, 32'h0000_0013);
        tick();
        tick();
        lat = 1;
        push(32'h0000_0000, 32'hC0DE_0000);
        rst_n          = 1'b1;
        if_ready       = 1'b1;
        imem_req_ready = 1'b1;
        wait_sb(40, "midrst_refetch");
        if_ready       = 1'b0;
        imem_req_ready = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
